// File: rtl/nvme_io_issue_pkg.sv
// nvme_io_issue shared types: id field layout, queue/track sizing, issue FSM.
// Imported by the interface, the credit array and the top.
package nvme_io_issue_pkg;

  localparam int CMD_ACTION_ID_BITS = 4;
  localparam int CMD_QUEUE_ID_BITS  = 4;
  localparam int REQ_ID_BITS        = 8;
  localparam int TRACK_NUM          = 8;
  localparam int NUM_ACTIONS        = 1 << CMD_ACTION_ID_BITS;
  localparam int OUT_BITS           = $clog2(TRACK_NUM + 1);
  localparam int CMD_SSD0_Q0        = 0;
  localparam int CMD_SSD1_Q0        = 8;

  localparam int CMD_ID_SQ_LSB  = 0;
  localparam int CMD_ID_ACT_LSB = CMD_QUEUE_ID_BITS;
  localparam int CMD_ID_REQ_LSB = CMD_QUEUE_ID_BITS + CMD_ACTION_ID_BITS;

  typedef logic [CMD_ACTION_ID_BITS-1:0] act_t;
  typedef logic [CMD_QUEUE_ID_BITS-1:0]  qid_t;
  typedef logic [REQ_ID_BITS-1:0]        req_t;
  typedef logic [OUT_BITS-1:0]           out_t;
  typedef logic [15:0]                   cmd_id_t;

  typedef enum logic {
    ISSUE_IDLE,
    ISSUE_HOLD
  } issue_state_e;

  function automatic logic is_admin(qid_t q);
    return (q == qid_t'(CMD_SSD0_Q0)) || (q == qid_t'(CMD_SSD1_Q0));
  endfunction

  function automatic cmd_id_t make_cmd_id(req_t r, act_t a, qid_t q);
    return {r, a, q};
  endfunction

endpackage

// File: rtl/nvme_io_issue_if.sv
// Command-in / SQ-out / retire bundle of nvme_io_issue.
// master drives requests and retires, slave is the issue block.
interface nvme_io_issue_if;
  import nvme_io_issue_pkg::*;

  logic    cmd_valid;
  logic    cmd_ready;
  act_t    cmd_action_id;
  qid_t    cmd_sq_index;
  logic    sq_valid;
  logic    sq_ready;
  cmd_id_t sq_cmd_id;
  logic    retire_valid;
  act_t    retire_action_id;

  modport master (
    output cmd_valid, cmd_action_id, cmd_sq_index,
    output sq_ready, retire_valid, retire_action_id,
    input  cmd_ready, sq_valid, sq_cmd_id
  );

  modport slave (
    input  cmd_valid, cmd_action_id, cmd_sq_index,
    input  sq_ready, retire_valid, retire_action_id,
    output cmd_ready, sq_valid, sq_cmd_id
  );

endinterface

// File: rtl/nvme_io_issue_credit.sv
// Per-action req_id counters and outstanding-command credits.
// Accept and retire on one action in the same cycle cancel out.
module nvme_io_issue_credit
  import nvme_io_issue_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  act_t                   action_i,
  output logic                   full_o,
  output req_t                   req_id_o,
  input  logic                   acc_i,
  input  logic                   ret_i,
  input  act_t                   ret_action_i,
  output logic [NUM_ACTIONS-1:0] busy_o,
  output logic                   underflow_o
);

  req_t req_q [NUM_ACTIONS];
  req_t req_d [NUM_ACTIONS];
  out_t out_q [NUM_ACTIONS];
  out_t out_d [NUM_ACTIONS];
  logic [NUM_ACTIONS-1:0] inc, dec, busy_q;
  logic underflow_q, underflow_d;

  assign full_o      = out_q[action_i] == out_t'(TRACK_NUM);
  assign req_id_o    = req_q[action_i];
  assign busy_o      = busy_q;
  assign underflow_o = underflow_q;

  always_comb begin
    for (int i = 0; i < NUM_ACTIONS; i++) begin
      inc[i] = acc_i && (action_i == act_t'(i));
      dec[i] = ret_i && (ret_action_i == act_t'(i))
               && (out_q[i] != '0);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ACTIONS; i++) begin
      req_d[i] = req_q[i];
      out_d[i] = out_q[i];
      if (inc[i]) begin
        req_d[i] = (req_q[i] == req_t'(TRACK_NUM - 1))
                   ? '0 : req_q[i] + req_t'(1);
      end
      if (inc[i] && !dec[i]) out_d[i] = out_q[i] + out_t'(1);
      if (!inc[i] && dec[i]) out_d[i] = out_q[i] - out_t'(1);
    end
    underflow_d = underflow_q
                  | (ret_i && (out_q[ret_action_i] == '0));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_ACTIONS; i++) begin
        req_q[i] <= '0;
        out_q[i] <= '0;
      end
      busy_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ACTIONS; i++) begin
        req_q[i]  <= req_d[i];
        out_q[i]  <= out_d[i];
        busy_q[i] <= out_q[i] != '0;
      end
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: rtl/nvme_io_issue.sv
// NVMe submission-side cmd_id stamping with per-action credits.
// Optional watchdog: define NVME_ISSUE_TIMEOUT_EN.
module nvme_io_issue
  import nvme_io_issue_pkg::*;
#(
  parameter int                     TIMEOUT_BITS  = 24,
  parameter logic [TIMEOUT_BITS-1:0] TIMEOUT_LIMIT = 24'hFFFFFF
) (
  input  logic                   axi_aclk,
  input  logic                   axi_areset,
  nvme_io_issue_if.slave         io,
  output logic [NUM_ACTIONS-1:0] issue_busy,
  output logic                   issue_underflow,
  output logic                   issue_timeout
);

  issue_state_e state_q, state_d;
  cmd_id_t id_q, id_d;
  logic admin, full, rdy, acc_io;
  req_t req_id;

  assign admin = is_admin(io.cmd_sq_index);

  nvme_io_issue_credit u_credit (
    .clk_i        (axi_aclk),
    .rst_i        (axi_areset),
    .action_i     (io.cmd_action_id),
    .full_o       (full),
    .req_id_o     (req_id),
    .acc_i        (acc_io),
    .ret_i        (io.retire_valid),
    .ret_action_i (io.retire_action_id),
    .busy_o       (issue_busy),
    .underflow_o  (issue_underflow)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    rdy     = 1'b0;
    acc_io  = 1'b0;
    unique case (state_q)
      ISSUE_IDLE: begin
        rdy = io.cmd_valid && !axi_areset && (admin || !full);
        acc_io = rdy && !admin;
        if (rdy) begin
          id_d = make_cmd_id(admin ? '0 : req_id,
                             io.cmd_action_id, io.cmd_sq_index);
          state_d = ISSUE_HOLD;
        end
      end
      ISSUE_HOLD: begin
        if (io.sq_ready) state_d = ISSUE_IDLE;
      end
      default: state_d = ISSUE_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q <= ISSUE_IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  assign io.cmd_ready = rdy;
  assign io.sq_valid  = state_q == ISSUE_HOLD;
  assign io.sq_cmd_id = id_q;

`ifdef NVME_ISSUE_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
  logic to_q;

  // any retire proves the tracker is alive, so it restarts the count
  always_comb begin
    wd_d = wd_q;
    if (io.retire_valid || ~|issue_busy) wd_d = '0;
    else if (wd_q != TIMEOUT_LIMIT) wd_d = wd_q + TIMEOUT_BITS'(1);
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_q | (wd_q == TIMEOUT_LIMIT);
    end
  end

  assign issue_timeout = to_q;
`else
  logic [TIMEOUT_BITS-1:0] unused_limit;
  assign unused_limit  = TIMEOUT_LIMIT;
  assign issue_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_nvme_io_issue.sv
// Scoreboard bench for nvme_io_issue: directed stimulus, queued ids.
// Timeout checks follow NVME_ISSUE_TIMEOUT_EN.
module tb_nvme_io_issue;
  import nvme_io_issue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_ACTIONS-1:0] busy;
  logic underflow, timeout;
  int tests = 0;
  int fails = 0;
  cmd_id_t exp_q[$];
  cmd_id_t e;

  nvme_io_issue_if bus ();

  nvme_io_issue #(
    .TIMEOUT_BITS  (24),
    .TIMEOUT_LIMIT (24'd100)
  ) dut (
    .axi_aclk        (clk),
    .axi_areset      (rst),
    .io              (bus),
    .issue_busy      (busy),
    .issue_underflow (underflow),
    .issue_timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.sq_valid && bus.sq_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sq_cmd_id: got %h expected none",
                 bus.sq_cmd_id);
      end else begin
        e = exp_q.pop_front();
        chk("sq_cmd_id", 32'(bus.sq_cmd_id), 32'(e));
      end
    end
  end

  task automatic send(input act_t a, input qid_t q,
                      input cmd_id_t exp, input bit push);
    int n;
    bus.cmd_valid     = 1'b1;
    bus.cmd_action_id = a;
    bus.cmd_sq_index  = q;
    if (push) exp_q.push_back(exp);
    #1;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_wait: got no cmd_ready expected %h", exp);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic retire(input act_t a);
    bus.retire_valid     = 1'b1;
    bus.retire_action_id = a;
    @(negedge clk);
    bus.retire_valid = 1'b0;
  endtask

  initial begin
    bus.cmd_valid        = 1'b1;
    bus.cmd_action_id    = 4'd0;
    bus.cmd_sq_index     = 4'd5;
    bus.sq_ready         = 1'b1;
    bus.retire_valid     = 1'b0;
    bus.retire_action_id = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("rst_sq_valid", 32'(bus.sq_valid), 0);
    chk("rst_sq_cmd_id", 32'(bus.sq_cmd_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_underflow", 32'(underflow), 0);
    chk("rst_timeout", 32'(timeout), 0);
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // three commands on action 2
    send(4'd2, 4'd5, 16'h0025, 1);
    send(4'd2, 4'd5, 16'h0125, 1);
    send(4'd2, 4'd5, 16'h0225, 1);
    repeat (2) @(negedge clk);
    chk("busy2", 32'(busy[2]), 1);

    // fill action 1, then one retire lets the wrapped id through
    for (int i = 0; i < TRACK_NUM; i++)
      send(4'd1, 4'd5, {8'(i), 4'd1, 4'd5}, 1);
    bus.cmd_valid     = 1'b1;
    bus.cmd_action_id = 4'd1;
    bus.cmd_sq_index  = 4'd5;
    repeat (2) @(negedge clk);
    #1;
    chk("full1_ready", 32'(bus.cmd_ready), 0);
    bus.retire_valid     = 1'b1;
    bus.retire_action_id = 4'd1;
    #1;
    chk("full1_retire_same_cycle", 32'(bus.cmd_ready), 0);
    @(negedge clk);
    bus.retire_valid = 1'b0;
    send(4'd1, 4'd5, 16'h0015, 1);

    // admin queues bypass a full action
    for (int i = 0; i < TRACK_NUM; i++)
      send(4'd3, 4'd5, {8'(i), 4'd3, 4'd5}, 1);
    send(4'd3, 4'd0, 16'h0030, 1);
    send(4'd3, 4'd8, 16'h0038, 1);
    bus.cmd_valid     = 1'b1;
    bus.cmd_action_id = 4'd3;
    bus.cmd_sq_index  = 4'd5;
    repeat (2) @(negedge clk);
    #1;
    chk("full3_after_admin", 32'(bus.cmd_ready), 0);
    bus.cmd_valid = 1'b0;
    @(negedge clk);

    // accept and retire on action 6 together
    send(4'd6, 4'd5, 16'h0065, 1);
    send(4'd6, 4'd5, 16'h0165, 1);
    @(negedge clk);
    bus.retire_valid     = 1'b1;
    bus.retire_action_id = 4'd6;
    send(4'd6, 4'd5, 16'h0265, 1);
    bus.retire_valid = 1'b0;
    retire(4'd6);
    retire(4'd6);
    repeat (2) @(negedge clk);
    chk("busy6_drained", 32'(busy[6]), 0);
    chk("no_underflow_yet", 32'(underflow), 0);
    send(4'd6, 4'd5, 16'h0365, 1);
    repeat (2) @(negedge clk);
    chk("busy6_again", 32'(busy[6]), 1);

    // underflow on an idle action is sticky
    retire(4'd4);
    chk("underflow_set", 32'(underflow), 1);
    repeat (5) @(negedge clk);
    chk("underflow_sticky", 32'(underflow), 1);
    chk("busy4", 32'(busy[4]), 0);

    repeat (50) @(negedge clk);
    chk("timeout_early", 32'(timeout), 0);
`ifdef NVME_ISSUE_TIMEOUT_EN
    begin
      int n = 0;
      while (!timeout && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_set", 32'(timeout), 1);
      repeat (3) @(negedge clk);
      chk("timeout_sticky", 32'(timeout), 1);
    end
`else
    repeat (150) @(negedge clk);
    chk("timeout_tied_off", 32'(timeout), 0);
`endif

    // reset while a command is held
    bus.sq_ready = 1'b0;
    send(4'd2, 4'd5, 16'h0325, 0);
    chk("hold_valid", 32'(bus.sq_valid), 1);
    chk("hold_id", 32'(bus.sq_cmd_id), 32'h0325);
    @(negedge clk);
    chk("hold_id_stable", 32'(bus.sq_cmd_id), 32'h0325);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sq_valid", 32'(bus.sq_valid), 0);
    chk("midrst_sq_cmd_id", 32'(bus.sq_cmd_id), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_underflow", 32'(underflow), 0);
    chk("midrst_timeout", 32'(timeout), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.sq_ready = 1'b1;
    @(negedge clk);
    send(4'd2, 4'd5, 16'h0025, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
